// File: rtl/memory_pkg.sv
// Shared types for the memory stage: pipeline bundles, data-bus request/response,
// memory-function encoding and the memory-stage FSM state.
package memory_pkg;

    typedef enum logic [1:0] {
        OP_ALU    = 2'd0,
        OP_LOAD   = 2'd1,
        OP_STORE  = 2'd2,
        OP_BRANCH = 2'd3
    } op_t;

    // Width/sign selector for loads and stores
    typedef enum logic [2:0] {
        MF_B  = 3'd0,
        MF_H  = 3'd1,
        MF_W  = 3'd2,
        MF_D  = 3'd3,
        MF_BU = 3'd4,
        MF_HU = 3'd5,
        MF_WU = 3'd6
    } memfunc_t;

    // Bus access size: 1/2/4/8 bytes
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        op_t      op;
        memfunc_t memfunc;
        logic     regwrite;
    } ctl_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [63:0] rd2;
        logic [63:0] result;
    } excute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [63:0] result;
        logic        misalign;
    } memory_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    // Access size implied by a memory function
    function automatic msize_t memfunc_size(input memfunc_t mf);
        case (mf)
            MF_B, MF_BU: return MSIZE1;
            MF_H, MF_HU: return MSIZE2;
            MF_W, MF_WU: return MSIZE4;
            default:     return MSIZE8;
        endcase
    endfunction

endpackage

// File: rtl/memory_mem_align.sv
// Byte-lane alignment for the memory stage: store strobe/data placement,
// load extraction with sign/zero extension, and misalignment detection.
module memory_mem_align
    import memory_pkg::*;
(
    input  logic [2:0]  i_off,
    input  memfunc_t    i_memfunc,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_rdata,
    output msize_t      o_size,
    output logic [7:0]  o_strobe,
    output logic [63:0] o_wdata,
    output logic [63:0] o_rdata,
    output logic        o_misalign
);

    logic [5:0]  w_shamt;
    logic [7:0]  w_base;
    logic [63:0] w_raw;

    assign w_shamt = {i_off, 3'b000};
    assign o_size  = memfunc_size(i_memfunc);

    // Base lane mask and natural-alignment check for the access size
    always_comb begin
        w_base     = 8'hFF;
        o_misalign = 1'b0;
        case (o_size)
            MSIZE1: begin w_base = 8'h01; o_misalign = 1'b0;        end
            MSIZE2: begin w_base = 8'h03; o_misalign = i_off[0];     end
            MSIZE4: begin w_base = 8'h0F; o_misalign = |i_off[1:0]; end
            default: begin w_base = 8'hFF; o_misalign = |i_off;     end
        endcase
    end

    assign o_strobe = w_base << i_off;
    assign o_wdata  = i_wdata << w_shamt;
    assign w_raw    = i_rdata >> w_shamt;

    // Extend the addressed bytes to 64 bits
    always_comb begin
        o_rdata = w_raw;
        case (i_memfunc)
            MF_B:    o_rdata = {{56{w_raw[7]}},  w_raw[7:0]};
            MF_H:    o_rdata = {{48{w_raw[15]}}, w_raw[15:0]};
            MF_W:    o_rdata = {{32{w_raw[31]}}, w_raw[31:0]};
            MF_BU:   o_rdata = {56'd0, w_raw[7:0]};
            MF_HU:   o_rdata = {48'd0, w_raw[15:0]};
            MF_WU:   o_rdata = {32'd0, w_raw[31:0]};
            default: o_rdata = w_raw;
        endcase
    end

endmodule

// File: rtl/memory.sv
// Memory pipeline stage: issues loads/stores on the data bus, stalls upstream
// while a transaction is outstanding, and registers the bundle for writeback.
module memory
    import memory_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  excute_data_t dataE,
    output memory_data_t dataM,
    output logic         stopm,
    output dbus_req_t    dreq,
    input  dbus_resp_t   dresp
);

    mem_state_t  r_state;
    dbus_req_t   r_req;
    dbus_req_t   w_req;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_memop;
    logic        w_misalign_raw;
    logic        w_misalign;
    logic        w_issue;
    msize_t      w_size;
    logic [7:0]  w_strobe;
    logic [63:0] w_wdata;
    logic [63:0] w_rdata_ext;
    logic        w_unused_addr_ok;

    // addr_ok is not needed: the request simply stays up until data_ok
    assign w_unused_addr_ok = dresp.addr_ok;

    assign w_is_load  = (dataE.ctl.op == OP_LOAD);
    assign w_is_store = (dataE.ctl.op == OP_STORE);
    assign w_memop    = dataE.valid && (w_is_load || w_is_store);
    assign w_misalign = w_memop && ALIGN_CHECK && w_misalign_raw;
    assign w_issue    = w_memop && !w_misalign;

    memory_mem_align u_align (
        .i_off      (dataE.result[2:0]),
        .i_memfunc  (dataE.ctl.memfunc),
        .i_wdata    (dataE.rd2),
        .i_rdata    (dresp.data),
        .o_size     (w_size),
        .o_strobe   (w_strobe),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata_ext),
        .o_misalign (w_misalign_raw)
    );

    // Request built directly from the execute bundle (loads drive no strobes)
    always_comb begin
        w_req        = '0;
        w_req.valid  = w_issue;
        w_req.addr   = dataE.result;
        w_req.size   = w_size;
        w_req.strobe = w_is_store ? w_strobe : 8'h00;
        w_req.data   = w_wdata;
    end

    // Bus request and stall: live request in IDLE, frozen copy in WAIT
    always_comb begin
        dreq = (r_state == WAIT) ? r_req : w_req;
        if (reset) begin
            dreq.valid = 1'b0;
        end
        stopm = dreq.valid && !dresp.data_ok;
    end

    // IDLE/WAIT sequencing; the request is snapshotted on entry to WAIT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_req   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue && !dresp.data_ok) begin
                        r_state <= WAIT;
                        r_req   <= w_req;
                    end
                end
                WAIT: begin
                    if (dresp.data_ok) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Writeback bundle: capture when not stalled, otherwise insert a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            dataM <= '0;
        end else if (!stopm) begin
            dataM.valid    <= dataE.valid;
            dataM.pc       <= dataE.pc;
            dataM.instr    <= dataE.instr;
            dataM.ctl      <= dataE.ctl;
            dataM.dst      <= dataE.dst;
            dataM.result   <= (w_issue && w_is_load) ? w_rdata_ext : dataE.result;
            dataM.misalign <= w_misalign;
        end else begin
            dataM.valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for the memory stage: stimulus pushes the expected writeback
// bundle, a negedge monitor pops and compares whenever dataM.valid is seen.
module tb_memory;
    import memory_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    excute_data_t dataE;
    memory_data_t dataM;
    logic         stopm;
    dbus_req_t    dreq;
    dbus_resp_t   dresp;

    int n_vec = 0;
    int n_err = 0;
    memory_data_t exp_q[$];

    always #5 clk = ~clk;

    memory #(.ALIGN_CHECK(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .dataE (dataE),
        .dataM (dataM),
        .stopm (stopm),
        .dreq  (dreq),
        .dresp (dresp)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    function automatic excute_data_t mk(input op_t op, input memfunc_t mf,
                                        input logic [63:0] res, input logic [63:0] rd2,
                                        input logic [63:0] pc);
        excute_data_t e;
        e             = '0;
        e.valid       = 1'b1;
        e.pc          = pc;
        e.instr       = pc[31:0] ^ 32'h0000_0013;
        e.ctl.op      = op;
        e.ctl.memfunc = mf;
        e.ctl.regwrite = (op != OP_STORE);
        e.dst         = pc[6:2];
        e.rd2         = rd2;
        e.result      = res;
        return e;
    endfunction

    // Monitor: every valid writeback bundle must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && dataM.valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL dataM_unexpected: got pc=%h result=%h expected no entry", dataM.pc, dataM.result);
            end else begin
                memory_data_t m;
                m = exp_q.pop_front();
                if (dataM.pc !== m.pc || dataM.instr !== m.instr || dataM.dst !== m.dst ||
                    dataM.result !== m.result || dataM.misalign !== m.misalign) begin
                    n_err++;
                    $display("FAIL dataM: got pc=%h result=%h mis=%b dst=%h expected pc=%h result=%h mis=%b dst=%h",
                             dataM.pc, dataM.result, dataM.misalign, dataM.dst,
                             m.pc, m.result, m.misalign, m.dst);
                end else begin
                    $display("ok   dataM: pc=%h result=%h mis=%b", dataM.pc, dataM.result, dataM.misalign);
                end
            end
        end
    end

    // Apply one execute bundle; data_ok arrives after 'waits' stall cycles
    task automatic run_op(input string nm, input excute_data_t e, input int waits,
                          input logic [63:0] rdata, input logic exp_req,
                          input logic [63:0] exp_result, input logic exp_mis,
                          input msize_t exp_size, input logic [7:0] exp_strobe,
                          input logic [63:0] exp_wdata);
        memory_data_t m;
        dbus_req_t    first;
        m          = '0;
        m.valid    = e.valid;
        m.pc       = e.pc;
        m.instr    = e.instr;
        m.ctl      = e.ctl;
        m.dst      = e.dst;
        m.result   = exp_result;
        m.misalign = exp_mis;
        exp_q.push_back(m);
        first = '0;
        dataE = e;
        dresp.addr_ok = exp_req;
        dresp.data_ok = exp_req && (waits == 0);
        dresp.data    = (waits == 0) ? rdata : 64'hDEAD_BEEF_DEAD_BEEF;
        for (int c = 0; c <= waits; c++) begin
            @(negedge clk);
            if (c == 0) first = dreq;
            chk({nm, "_stopm"}, {63'd0, stopm}, {63'd0, (c < waits)});
            chk({nm, "_dreq_valid"}, {63'd0, dreq.valid}, {63'd0, exp_req});
            if (exp_req) begin
                chk({nm, "_addr"}, dreq.addr, e.result);
                chk({nm, "_size"}, {62'd0, dreq.size}, {62'd0, exp_size});
                if (e.ctl.op == OP_STORE) begin
                    chk({nm, "_strobe"}, {56'd0, dreq.strobe}, {56'd0, exp_strobe});
                    chk({nm, "_wdata"}, dreq.data, exp_wdata);
                end
                if (c > 0) chk({nm, "_dreq_stable"}, {63'd0, (dreq === first)}, 64'd1);
            end
            @(posedge clk);
            #1;
            if (c + 1 == waits) begin
                dresp.data_ok = 1'b1;
                dresp.data    = rdata;
            end
        end
        dresp.data_ok = 1'b0;
        dresp.addr_ok = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        excute_data_t e;
        reset = 1'b1;
        dataE = '0;
        dresp = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_dataM_valid", {63'd0, dataM.valid}, 64'd0);
        chk("rst_dataM_result", dataM.result, 64'd0);
        chk("rst_dataM_misalign", {63'd0, dataM.misalign}, 64'd0);
        chk("rst_stopm", {63'd0, stopm}, 64'd0);
        chk("rst_dreq_valid", {63'd0, dreq.valid}, 64'd0);
        @(posedge clk);
        #1;

        // Loads: immediate and delayed data_ok, signed and unsigned extraction
        run_op("LD", mk(OP_LOAD, MF_D, 64'h8000_1000, 64'd0, 64'h100), 0,
               64'h1122_3344_5566_7788, 1'b1, 64'h1122_3344_5566_7788, 1'b0, MSIZE8, 8'h00, 64'd0);
        run_op("LB", mk(OP_LOAD, MF_B, 64'h8000_1003, 64'd0, 64'h104), 3,
               64'h0123_4567_9ABC_DEF0, 1'b1, 64'hFFFF_FFFF_FFFF_FF9A, 1'b0, MSIZE1, 8'h00, 64'd0);
        run_op("LBU", mk(OP_LOAD, MF_BU, 64'h8000_1003, 64'd0, 64'h108), 1,
               64'h0123_4567_9ABC_DEF0, 1'b1, 64'h0000_0000_0000_009A, 1'b0, MSIZE1, 8'h00, 64'd0);
        run_op("LH", mk(OP_LOAD, MF_H, 64'h8000_1006, 64'd0, 64'h10C), 0,
               64'h8001_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 1'b0, MSIZE2, 8'h00, 64'd0);
        run_op("LHU", mk(OP_LOAD, MF_HU, 64'h8000_1006, 64'd0, 64'h110), 0,
               64'h8001_0000_0000_0000, 1'b1, 64'h0000_0000_0000_8001, 1'b0, MSIZE2, 8'h00, 64'd0);
        run_op("LW", mk(OP_LOAD, MF_W, 64'h8000_1004, 64'd0, 64'h114), 2,
               64'h89AB_CDEF_0000_0000, 1'b1, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, MSIZE4, 8'h00, 64'd0);
        run_op("LWU", mk(OP_LOAD, MF_WU, 64'h8000_1004, 64'd0, 64'h118), 0,
               64'h89AB_CDEF_0000_0000, 1'b1, 64'h0000_0000_89AB_CDEF, 1'b0, MSIZE4, 8'h00, 64'd0);

        // Stores: lane placement of strobe and data
        run_op("SB", mk(OP_STORE, MF_B, 64'h8000_2005, 64'h0000_0000_0000_00AB, 64'h11C), 0,
               64'd0, 1'b1, 64'h8000_2005, 1'b0, MSIZE1, 8'h20, 64'h0000_AB00_0000_0000);
        run_op("SW", mk(OP_STORE, MF_W, 64'h8000_2004, 64'h0000_0000_1122_3344, 64'h120), 1,
               64'd0, 1'b1, 64'h8000_2004, 1'b0, MSIZE4, 8'hF0, 64'h1122_3344_0000_0000);
        run_op("SH", mk(OP_STORE, MF_H, 64'h8000_2002, 64'h0000_0000_0000_BEEF, 64'h124), 0,
               64'd0, 1'b1, 64'h8000_2002, 1'b0, MSIZE2, 8'h0C, 64'h0000_0000_BEEF_0000);
        run_op("SD", mk(OP_STORE, MF_D, 64'h8000_2008, 64'h0102_0304_0506_0708, 64'h128), 2,
               64'd0, 1'b1, 64'h8000_2008, 1'b0, MSIZE8, 8'hFF, 64'h0102_0304_0506_0708);

        // ALU / LD / ALU back to back with no bubble
        run_op("ALU1", mk(OP_ALU, MF_D, 64'h0000_0000_0000_1234, 64'h55, 64'h12C), 0,
               64'd0, 1'b0, 64'h0000_0000_0000_1234, 1'b0, MSIZE8, 8'h00, 64'd0);
        run_op("LD2", mk(OP_LOAD, MF_D, 64'h8000_1000, 64'd0, 64'h130), 0,
               64'hCAFE_F00D_1234_5678, 1'b1, 64'hCAFE_F00D_1234_5678, 1'b0, MSIZE8, 8'h00, 64'd0);
        run_op("ALU2", mk(OP_ALU, MF_D, 64'h0000_0000_0000_5678, 64'h66, 64'h134), 0,
               64'd0, 1'b0, 64'h0000_0000_0000_5678, 1'b0, MSIZE8, 8'h00, 64'd0);

        // Misaligned word load is suppressed and flagged
        run_op("LW_MIS", mk(OP_LOAD, MF_W, 64'h8000_3002, 64'd0, 64'h138), 0,
               64'd0, 1'b0, 64'h8000_3002, 1'b1, MSIZE4, 8'h00, 64'd0);

        // Reset while stalled in WAIT abandons the request
        e = mk(OP_LOAD, MF_D, 64'h8000_4000, 64'd0, 64'h13C);
        dataE = e;
        dresp.data_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("RST_WAIT_stopm", {63'd0, stopm}, 64'd1);
            chk("RST_WAIT_dreq_valid", {63'd0, dreq.valid}, 64'd1);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        dataE = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("POSTRST_dreq_valid", {63'd0, dreq.valid}, 64'd0);
        chk("POSTRST_stopm", {63'd0, stopm}, 64'd0);
        chk("POSTRST_dataM_valid", {63'd0, dataM.valid}, 64'd0);
        @(posedge clk);
        #1;
        run_op("LD_AFTER_RST", mk(OP_LOAD, MF_D, 64'h8000_4008, 64'd0, 64'h140), 1,
               64'h0F0E_0D0C_0B0A_0908, 1'b1, 64'h0F0E_0D0C_0B0A_0908, 1'b0, MSIZE8, 8'h00, 64'd0);

        dataE = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
